voting_session_ctrl: RTL and testbench
======================================

# voting_session_ctrl

Session controller that sequences the `voting_machine` counter datapath through one election. It accepts polling-officer commands and raw voter buttons, and issues exactly one single-cycle vote pulse per issued ballot. It drives `voting_over` when the polls close and keeps voter, spoiled and expired ballot tallies. It sits between the front-panel inputs and the candidate/`voting_over` inputs of `voting_machine`.

## Interface
- `TIMEOUT_CYCLES`, 1000: cycles an armed ballot waits for a press before expiring (≥2).
- `CNT_W`, 32: width of all tally outputs.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `i_open_polls`  in  1  officer opens the session (level, sampled in IDLE).
- `i_issue_ballot`  in  1  officer arms one ballot (level, sampled in READY).
- `i_close_polls`  in  1  officer closes the session.
- `i_candidate_1..3`  in  1 each  raw voter buttons, synchronous to `clk`.
- `o_vote_1..3`  out  1 each  single-cycle vote pulses to `voting_machine`.
- `o_voting_over`  out  1  high for as long as the state is CLOSED.
- `o_ballot_armed`  out  1  voter lamp; high in ARMED.
- `o_voters`  out  CNT_W  accepted ballots.
- `o_spoiled`  out  CNT_W  ballots with more than one simultaneous press.
- `o_expired`  out  CNT_W  ballots that timed out.

## Operation
- States: IDLE, READY, ARMED, CAST, CLOSED.
- IDLE → READY on `i_open_polls`. All other inputs are ignored in IDLE.
- READY → CLOSED on `i_close_polls`. Otherwise READY → ARMED on `i_issue_ballot`. Close wins if both are high.
- ARMED:
  - Button rising edges only are used: `edge_x = i_candidate_x & ~prev_x`. `prev_x` registers every cycle in every state.
  - A button already held when ARMED is entered does not vote until it is released and pressed again.
  - Exactly one edge → CAST. The winning candidate is latched.
  - Two or more edges in the same cycle → READY, `o_spoiled`+1.
  - Timeout reached with no edge → READY, `o_expired`+1.
  - `i_close_polls` with no edge → CLOSED; the ballot is discarded without being tallied.
  - Priority: a valid single edge beats close, and close beats timeout. A spoil also beats close: it is tallied and the next state is READY.
  - `i_issue_ballot` is ignored.
- CAST: lasts one cycle, drives the latched `o_vote_x` high, `o_voters`+1, then → READY. Buttons and commands are ignored.
- CLOSED is terminal until reset. No further pulses or tally changes.
- Tallies wrap modulo 2^CNT_W.
- Invariant: at most one `o_vote_x` is high in any cycle.

## Timing
- Reset (`rst`=0 at an edge), in any state: next cycle is IDLE. All outputs, tallies, `prev_x`, the latched candidate and the timeout counter are 0. An in-flight CAST pulse is suppressed.
- Press latency: an edge sampled at clock edge k puts the state in CAST during cycle k→k+1. `o_vote_x` is high exactly that cycle. `o_voters` shows the new value from edge k+1.
- Timeout counter:
  - Clears on ARMED entry and increments each ARMED cycle.
  - The ballot expires at the edge where the counter equals TIMEOUT_CYCLES−1, so ARMED lasts exactly TIMEOUT_CYCLES cycles.
  - A press sampled on that same edge is accepted.
- Registered outputs change only on `clk` edges. `o_voting_over` rises on the edge entering CLOSED.
- Minimum ballot cycle: READY → ARMED → CAST → READY = 3 cycles.

## Configuration
- `VOTE_TIMEOUT_EN`
  - Defined: timeout counter and expiry behave as specified.
  - Undefined: the counter is not built, ARMED waits indefinitely, and `o_expired` is tied to 0. TIMEOUT_CYCLES is unused.

## Structure
- `voting_pkg` holds the `session_state_t` enum (IDLE, READY, ARMED, CAST, CLOSED), the constant `N_CANDIDATES = 3`, and the default CNT_W.
- Sub-module `vote_edge_detect`: N-bit register of previous button values plus rising-edge vector output, cleared by `rst`. It is instantiated once with 3 bits.

## Test plan
Directed tests use TIMEOUT_CYCLES=16.
- Normal flow: open, issue, press cand 1; issue, press 2; issue, press 1; close → exactly one pulse per press, `o_voters`=3, `voting_machine` counts 2/1/0, `o_voting_over`=1.
- Simultaneous press: cand 2 and cand 3 rise in the same ARMED cycle → no pulse, `o_spoiled`=1, state READY.
- Held button: cand 3 held from READY through ARMED entry → no vote. Release then press → one `o_vote_3` pulse.
- Timeout: issue, no press for 16 cycles → `o_expired`=1, back to READY. A press on cycle 16 instead → accepted.
- Close while armed: close and cand 1 edge in the same cycle → vote counted, then READY. Close alone → CLOSED, `o_voters` unchanged.
- Reset mid-CAST: `rst`=0 during CAST → no pulse next cycle, all tallies 0, IDLE.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared types and constants for the voting session controller.
package voting_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    ARMED,
    CAST,
    CLOSED
  } session_state_t;

  localparam int N_CANDIDATES = 3;
  localparam int CNT_W_DEF    = 32;

endpackage

// File: rtl/vote_edge_detect.sv
// Registers the previous button levels every cycle and flags rising edges.
module vote_edge_detect #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/voting_session_ctrl.sv
// Election session sequencer: one vote pulse per issued ballot, plus tallies.
// Ballot expiry is built only when VOTE_TIMEOUT_EN is defined.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_open_polls,
  input  logic             i_issue_ballot,
  input  logic             i_close_polls,
  input  logic             i_candidate_1,
  input  logic             i_candidate_2,
  input  logic             i_candidate_3,
  output logic             o_vote_1,
  output logic             o_vote_2,
  output logic             o_vote_3,
  output logic             o_voting_over,
  output logic             o_ballot_armed,
  output logic [CNT_W-1:0] o_voters,
  output logic [CNT_W-1:0] o_spoiled,
  output logic [CNT_W-1:0] o_expired
);

  logic [N_CANDIDATES-1:0] btn, rise;
  logic                    single_edge, multi_edge;

  session_state_t          state_q, state_d;
  logic [N_CANDIDATES-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]        voters_q, voters_d;
  logic [CNT_W-1:0]        spoiled_q, spoiled_d;

  assign btn = {i_candidate_3, i_candidate_2, i_candidate_1};

  vote_edge_detect #(.N(N_CANDIDATES)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn),
    .rise_o (rise)
  );

  assign single_edge = ($countones(rise) == 1);
  assign multi_edge  = ($countones(rise) > 1);

`ifdef VOTE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] expired_q, expired_d;
  logic             timeout_hit;

  assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside ARMED, so it is already clear on ARMED entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q     <= '0;
      expired_q <= '0;
    end else begin
      tmo_q     <= (state_q == ARMED) ? tmo_q + TMO_W'(1) : '0;
      expired_q <= expired_d;
    end
  end

  assign o_expired = expired_q;
`else
  assign o_expired = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      voters_q  <= '0;
      spoiled_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      voters_q  <= voters_d;
      spoiled_q <= spoiled_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    voters_d  = voters_q;
    spoiled_d = spoiled_q;
`ifdef VOTE_TIMEOUT_EN
    expired_d = expired_q;
`endif
    case (state_q)
      IDLE: if (i_open_polls) state_d = READY;
      READY: begin
        if (i_close_polls)       state_d = CLOSED;
        else if (i_issue_ballot) state_d = ARMED;
      end
      // Order sets priority: single press > spoil > close > expiry.
      ARMED: begin
        if (single_edge) begin
          state_d = CAST;
          cand_d  = rise;
        end else if (multi_edge) begin
          state_d   = READY;
          spoiled_d = spoiled_q + CNT_W'(1);
        end else if (i_close_polls) begin
          state_d = CLOSED;
        end
`ifdef VOTE_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d   = READY;
          expired_d = expired_q + CNT_W'(1);
        end
`endif
      end
      CAST: begin
        state_d  = READY;
        voters_d = voters_q + CNT_W'(1);
      end
      CLOSED:  state_d = CLOSED;
      default: state_d = IDLE;
    endcase
  end

  assign o_vote_1       = (state_q == CAST) & cand_q[0];
  assign o_vote_2       = (state_q == CAST) & cand_q[1];
  assign o_vote_3       = (state_q == CAST) & cand_q[2];
  assign o_voting_over  = (state_q == CLOSED);
  assign o_ballot_armed = (state_q == ARMED);
  assign o_voters       = voters_q;
  assign o_spoiled      = spoiled_q;

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Directed bench for voting_session_ctrl with a vote-pulse scoreboard.
module tb_voting_session_ctrl;

  localparam int TMO = 16;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_open_polls = 1'b0, i_issue_ballot = 1'b0, i_close_polls = 1'b0;
  logic          i_candidate_1 = 1'b0, i_candidate_2 = 1'b0, i_candidate_3 = 1'b0;
  logic          o_vote_1, o_vote_2, o_vote_3, o_voting_over, o_ballot_armed;
  logic [CW-1:0] o_voters, o_spoiled, o_expired;

  voting_session_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_open_polls   (i_open_polls),
    .i_issue_ballot (i_issue_ballot),
    .i_close_polls  (i_close_polls),
    .i_candidate_1  (i_candidate_1),
    .i_candidate_2  (i_candidate_2),
    .i_candidate_3  (i_candidate_3),
    .o_vote_1       (o_vote_1),
    .o_vote_2       (o_vote_2),
    .o_vote_3       (o_vote_3),
    .o_voting_over  (o_voting_over),
    .o_ballot_armed (o_ballot_armed),
    .o_voters       (o_voters),
    .o_spoiled      (o_spoiled),
    .o_expired      (o_expired)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int seen1 = 0, seen2 = 0, seen3 = 0;
  int exp_voters = 0;
  logic [2:0] mon_v;
  int mon_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vote_vec();
    return {29'd0, o_vote_3, o_vote_2, o_vote_1};
  endfunction

  task automatic set_cand(input int c, input logic v);
    case (c)
      1: i_candidate_1 = v;
      2: i_candidate_2 = v;
      default: i_candidate_3 = v;
    endcase
  endtask

  // Scoreboard: every observed pulse must match the oldest expected press.
  always @(negedge clk) begin
    mon_v = {o_vote_3, o_vote_2, o_vote_1};
    if (mon_v != 3'd0) begin
      check("one_hot_vote", $countones(mon_v), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, mon_v}, 0);
      end else begin
        mon_c = exp_q.pop_front();
        check("pulse_cand", {29'd0, mon_v}, 32'd1 << (mon_c - 1));
      end
      if (mon_v[0]) seen1++;
      if (mon_v[1]) seen2++;
      if (mon_v[2]) seen3++;
    end
  end

  task automatic reset_dut();
    rst = 1'b0;
    i_open_polls = 0; i_issue_ballot = 0; i_close_polls = 0;
    i_candidate_1 = 0; i_candidate_2 = 0; i_candidate_3 = 0;
    tick(); tick();
    rst = 1'b1;
    exp_voters = 0;
    exp_q.delete();
    seen1 = 0; seen2 = 0; seen3 = 0;
  endtask

  task automatic open_polls();
    i_open_polls = 1; tick(); i_open_polls = 0;
  endtask

  task automatic cast(input int c);
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    check("armed_lamp", o_ballot_armed, 1);
    set_cand(c, 1); exp_q.push_back(c); tick();
    check("vote_pulse", vote_vec(), 32'd1 << (c - 1));
    set_cand(c, 0); tick();
    exp_voters++;
    check("voters_after_cast", o_voters, exp_voters);
  endtask

  initial begin
    // Reset state
    reset_dut();
    check("rst_voters", o_voters, 0);
    check("rst_spoiled", o_spoiled, 0);
    check("rst_expired", o_expired, 0);
    check("rst_over", o_voting_over, 0);
    check("rst_armed", o_ballot_armed, 0);
    check("rst_votes", vote_vec(), 0);

    // Normal flow
    open_polls();
    cast(1); cast(2); cast(1);
    i_close_polls = 1; tick(); i_close_polls = 0;
    check("closed_over", o_voting_over, 1);
    check("closed_voters", o_voters, 3);
    check("count_cand1", seen1, 2);
    check("count_cand2", seen2, 1);
    check("count_cand3", seen3, 0);
    i_issue_ballot = 1; i_candidate_1 = 1; tick(); tick();
    i_issue_ballot = 0; i_candidate_1 = 0; tick();
    check("closed_terminal_over", o_voting_over, 1);
    check("closed_terminal_voters", o_voters, 3);
    check("closed_terminal_armed", o_ballot_armed, 0);

    // Simultaneous press spoils the ballot
    reset_dut();
    open_polls();
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    i_candidate_2 = 1; i_candidate_3 = 1; tick();
    check("spoil_armed", o_ballot_armed, 0);
    check("spoil_count", o_spoiled, 1);
    check("spoil_voters", o_voters, 0);
    i_candidate_2 = 0; i_candidate_3 = 0; tick();

    // Button held across ARMED entry must be released first
    i_candidate_3 = 1; tick();
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    tick(); tick();
    check("held_still_armed", o_ballot_armed, 1);
    i_candidate_3 = 0; tick();
    i_candidate_3 = 1; exp_q.push_back(3); tick();
    check("held_then_press", vote_vec(), 32'd4);
    i_candidate_3 = 0; tick();
    exp_voters++;
    check("held_voters", o_voters, exp_voters);

`ifdef VOTE_TIMEOUT_EN
    // Expiry after exactly TMO armed cycles
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    repeat (TMO - 1) tick();
    check("tmo_last_cycle_armed", o_ballot_armed, 1);
    check("tmo_not_yet", o_expired, 0);
    tick();
    check("tmo_expired_armed", o_ballot_armed, 0);
    check("tmo_expired", o_expired, 1);
    // Press on the final armed cycle is accepted
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    repeat (TMO - 1) tick();
    i_candidate_1 = 1; exp_q.push_back(1); tick();
    check("tmo_edge_press", vote_vec(), 32'd1);
    i_candidate_1 = 0; tick();
    exp_voters++;
    check("tmo_edge_voters", o_voters, exp_voters);
    check("tmo_edge_expired", o_expired, 1);
`else
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    repeat (3 * TMO) tick();
    check("notmo_armed", o_ballot_armed, 1);
    check("notmo_expired", o_expired, 0);
    i_candidate_1 = 1; exp_q.push_back(1); tick();
    check("notmo_press", vote_vec(), 32'd1);
    i_candidate_1 = 0; tick();
    exp_voters++;
    check("notmo_voters", o_voters, exp_voters);
`endif

    // Press beats close in the same cycle
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    i_close_polls = 1; i_candidate_1 = 1; exp_q.push_back(1); tick();
    check("close_press_vote", vote_vec(), 32'd1);
    i_close_polls = 0; i_candidate_1 = 0; tick();
    exp_voters++;
    check("close_press_voters", o_voters, exp_voters);
    check("close_press_over", o_voting_over, 0);
    check("close_press_armed", o_ballot_armed, 0);
    // Close alone discards the armed ballot
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    check("close_alone_armed", o_ballot_armed, 1);
    i_close_polls = 1; tick(); i_close_polls = 0;
    check("close_alone_over", o_voting_over, 1);
    check("close_alone_voters", o_voters, exp_voters);

    // Reset during CAST suppresses the pulse and clears tallies
    reset_dut();
    open_polls();
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    i_candidate_2 = 1; exp_q.push_back(2); tick();
    check("rcast_pulse", vote_vec(), 32'd2);
    rst = 1'b0; tick();
    check("rcast_votes", vote_vec(), 0);
    check("rcast_voters", o_voters, 0);
    check("rcast_spoiled", o_spoiled, 0);
    check("rcast_expired", o_expired, 0);
    check("rcast_over", o_voting_over, 0);
    rst = 1'b1; i_candidate_2 = 0;
    i_issue_ballot = 1; tick(); i_issue_ballot = 0;
    check("rcast_idle_ignores_issue", o_ballot_armed, 0);
    tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
